// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback port arbiter.
//   REG_ADDR_W / XLEN : register address and data widths
//   wb_src_e          : source tag reported with each register-file write
//   arb_state_e       : arbiter FSM states
package wb_arb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'b00,
    WB_SRC_PIPE = 2'b01,
    WB_SRC_MDU  = 2'b10,
    WB_SRC_HOLD = 2'b11
  } wb_src_e;

  typedef enum logic {
    ST_PIPE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;
endpackage

// File: rtl/wb_hold_reg.sv
// One-entry rd/data holding register for a displaced pipeline writeback.
//   clk, rst         : clock, synchronous active-high reset (empties entry)
//   load             : capture d_rd/d_data
//   clear            : empty the entry (load wins if both asserted)
//   d_rd, d_data     : entry to capture
//   q_rd, q_data     : held entry
module wb_hold_reg
  import wb_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic [XLEN-1:0]       d_data,
  output logic [REG_ADDR_W-1:0] q_rd,
  output logic [XLEN-1:0]       q_data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd   <= '0;
      q_data <= '0;
    end else if (load) begin
      q_rd   <= d_rd;
      q_data <= d_data;
    end else if (clear) begin
      q_rd   <= '0;
      q_data <= '0;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the in-order
// pipeline writeback and the MDU result. When both want the port, the MDU
// wins and the pipeline entry is parked in a one-entry hold buffer and
// written the following cycle (pipeline stalled for exactly that cycle).
// A wait counter forces an MDU grant after MAX_WAIT consecutive losses.
//   clk_in, rst_in              : clock, synchronous active-high reset
//   pipe_*_in                   : pipeline writeback entry
//   pipe_stall_out              : pipeline holds its writeback inputs (registered)
//   mdu_valid_in/rd/data        : MDU result, held stable until accepted
//   mdu_ready_out               : MDU result accepted this cycle (combinational)
//   rf_wr_en/rd_addr/wr_data_out: register-file write port (registered)
//   wb_src_out                  : source of current write (wb_src_e)
// Optional macro WB_ARB_PERF_EN adds conflict_cnt_out / starve_cnt_out.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  pipe_valid_in,
  input  logic                  pipe_rf_wr_en_in,
  input  logic [REG_ADDR_W-1:0] pipe_rd_in,
  input  logic [XLEN-1:0]       pipe_data_in,
  output logic                  pipe_stall_out,
  input  logic                  mdu_valid_in,
  input  logic [REG_ADDR_W-1:0] mdu_rd_in,
  input  logic [XLEN-1:0]       mdu_data_in,
  output logic                  mdu_ready_out,
  output logic                  rf_wr_en_out,
  output logic [REG_ADDR_W-1:0] rf_rd_addr_out,
  output logic [XLEN-1:0]       rf_wr_data_out,
  output logic [1:0]            wb_src_out
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]           conflict_cnt_out,
  output logic [31:0]           starve_cnt_out
`endif
);
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e            state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [REG_ADDR_W-1:0] held_rd;
  logic [XLEN-1:0]       held_data;

  logic in_pipe, pipe_wr, rd_match, wait_full, mdu_grant, conflict;

  assign in_pipe   = (state == ST_PIPE);
  assign pipe_wr   = pipe_valid_in & pipe_rf_wr_en_in & in_pipe;
  assign rd_match  = (mdu_rd_in == pipe_rd_in);
  assign wait_full = (wait_cnt == WAIT_MAX);
  // Same-rd forces the older MDU result out first so the younger pipe value
  // is the one left in the register.
  assign mdu_grant = in_pipe & mdu_valid_in & (~pipe_wr | wait_full | rd_match);
  assign conflict  = mdu_grant & pipe_wr;

  assign mdu_ready_out = mdu_grant & ~rst_in;

  wb_hold_reg u_hold (
    .clk    (clk_in),
    .rst    (rst_in),
    .load   (conflict),
    .clear  (~in_pipe),
    .d_rd   (pipe_rd_in),
    .d_data (pipe_data_in),
    .q_rd   (held_rd),
    .q_data (held_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_PIPE;
      wait_cnt       <= '0;
      pipe_stall_out <= 1'b0;
      rf_wr_en_out   <= 1'b0;
      rf_rd_addr_out <= '0;
      rf_wr_data_out <= '0;
      wb_src_out     <= WB_SRC_NONE;
    end else begin
      if (mdu_grant || !mdu_valid_in)
        wait_cnt <= '0;
      else if (!wait_full)
        wait_cnt <= wait_cnt + 1'b1;

      // Stall exactly for the cycle spent draining the hold buffer.
      pipe_stall_out <= conflict;

      case (state)
        ST_HOLD: begin
          rf_wr_en_out   <= (held_rd != '0);
          rf_rd_addr_out <= held_rd;
          rf_wr_data_out <= held_data;
          wb_src_out     <= WB_SRC_HOLD;
          state          <= ST_PIPE;
        end
        default: begin
          if (mdu_grant) begin
            rf_wr_en_out   <= (mdu_rd_in != '0);
            rf_rd_addr_out <= mdu_rd_in;
            rf_wr_data_out <= mdu_data_in;
            wb_src_out     <= WB_SRC_MDU;
            state          <= conflict ? ST_HOLD : ST_PIPE;
          end else if (pipe_wr) begin
            rf_wr_en_out   <= (pipe_rd_in != '0);
            rf_rd_addr_out <= pipe_rd_in;
            rf_wr_data_out <= pipe_data_in;
            wb_src_out     <= WB_SRC_PIPE;
            state          <= ST_PIPE;
          end else begin
            rf_wr_en_out   <= 1'b0;
            rf_rd_addr_out <= '0;
            rf_wr_data_out <= '0;
            wb_src_out     <= WB_SRC_NONE;
            state          <= ST_PIPE;
          end
        end
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      conflict_cnt_out <= '0;
      starve_cnt_out   <= '0;
    end else begin
      if (conflict)
        conflict_cnt_out <= conflict_cnt_out + 32'd1;
      if (mdu_grant && wait_full)
        starve_cnt_out <= starve_cnt_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        pipe_valid_in, pipe_rf_wr_en_in;
  logic [4:0]  pipe_rd_in;
  logic [31:0] pipe_data_in;
  logic        pipe_stall_out;
  logic        mdu_valid_in;
  logic [4:0]  mdu_rd_in;
  logic [31:0] mdu_data_in;
  logic        mdu_ready_out;
  logic        rf_wr_en_out;
  logic [4:0]  rf_rd_addr_out;
  logic [31:0] rf_wr_data_out;
  logic [1:0]  wb_src_out;
`ifdef WB_ARB_PERF_EN
  logic [31:0] conflict_cnt_out, starve_cnt_out;
`endif

  wb_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .pipe_valid_in    (pipe_valid_in),
    .pipe_rf_wr_en_in (pipe_rf_wr_en_in),
    .pipe_rd_in       (pipe_rd_in),
    .pipe_data_in     (pipe_data_in),
    .pipe_stall_out   (pipe_stall_out),
    .mdu_valid_in     (mdu_valid_in),
    .mdu_rd_in        (mdu_rd_in),
    .mdu_data_in      (mdu_data_in),
    .mdu_ready_out    (mdu_ready_out),
    .rf_wr_en_out     (rf_wr_en_out),
    .rf_rd_addr_out   (rf_rd_addr_out),
    .rf_wr_data_out   (rf_wr_data_out),
    .wb_src_out       (wb_src_out)
`ifdef WB_ARB_PERF_EN
    ,
    .conflict_cnt_out (conflict_cnt_out),
    .starve_cnt_out   (starve_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst;
    logic        pv, pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdata;
    // expectations: ready during the cycle, the rest after the edge
    logic        e_ready, e_stall, e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_src;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic rst, input logic pv, input logic pwe,
                              input logic [4:0] prd, input logic [31:0] pdata,
                              input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                              input logic e_ready, input logic e_stall, input logic e_en,
                              input logic [4:0] e_addr, input logic [31:0] e_data,
                              input logic [1:0] e_src);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pwe = pwe; v.prd = prd; v.pdata = pdata;
    v.mv = mv; v.mrd = mrd; v.mdata = mdata;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_en = e_en;
    v.e_addr = e_addr; v.e_data = e_data; v.e_src = e_src;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_in = v.rst;
    pipe_valid_in = v.pv; pipe_rf_wr_en_in = v.pwe;
    pipe_rd_in = v.prd; pipe_data_in = v.pdata;
    mdu_valid_in = v.mv; mdu_rd_in = v.mrd; mdu_data_in = v.mdata;
  endtask

  task automatic apply(input string name, input vec_t v);
    @(negedge clk_in);
    drive(v);
    #1;
    chk({name, ".ready"}, 64'(mdu_ready_out), 64'(v.e_ready));
    @(posedge clk_in);
    #1;
    chk({name, ".out{stall,en,addr,data,src}"},
        64'({pipe_stall_out, rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out, wb_src_out}),
        64'({v.e_stall, v.e_en, v.e_addr, v.e_data, v.e_src}));
  endtask

  // Reference model: tracks whether a displaced pipe entry is waiting, how
  // many cycles the current MDU request has been passed over, and what the
  // register-file port must show after each edge.
  bit          m_parked;
  int          m_losses;
  logic [4:0]  m_prd;
  logic [31:0] m_pdata;

  function automatic vec_t model_step(input vec_t v);
    vec_t r = v;
    bit pipe_wants, mdu_wins;
    pipe_wants = v.pv && v.pwe && !m_parked;
    mdu_wins   = !m_parked && v.mv &&
                 (!pipe_wants || m_losses >= MAX_WAIT || v.mrd == v.prd);
    r.e_ready = mdu_wins && !v.rst;
    r.e_stall = 0; r.e_en = 0; r.e_addr = 0; r.e_data = 0; r.e_src = 2'd0;
    if (v.rst) begin
      m_parked = 0; m_losses = 0;
      r.e_ready = 0;
      return r;
    end
    if (m_parked) begin
      r.e_src = 2'd3; r.e_addr = m_prd; r.e_data = m_pdata; r.e_en = (m_prd != 0);
      m_parked = 0;
    end else if (mdu_wins) begin
      r.e_src = 2'd2; r.e_addr = v.mrd; r.e_data = v.mdata; r.e_en = (v.mrd != 0);
      if (pipe_wants) begin
        m_parked = 1; m_prd = v.prd; m_pdata = v.pdata; r.e_stall = 1;
      end
    end else if (pipe_wants) begin
      r.e_src = 2'd1; r.e_addr = v.prd; r.e_data = v.pdata; r.e_en = (v.prd != 0);
    end
    if (mdu_wins || !v.mv) m_losses = 0;
    else if (m_losses < MAX_WAIT) m_losses++;
    return r;
  endfunction

  vec_t tbl[8];
  vec_t seq[$];

  initial begin
    vec_t v, cur;
    bit mdu_pend;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;

    //           rst pv pwe prd  pdata   mv mrd mdata      rdy stl en addr data     src
    tbl[0] = mk(1, 0, 0, 0,  0,       0, 0,  0,         0,  0,  0, 0,  0,       0);
    tbl[1] = mk(0, 1, 1, 5,  32'h11,  0, 0,  0,         0,  0,  1, 5,  32'h11,  1);
    tbl[2] = mk(0, 0, 0, 0,  0,       1, 7,  32'hABCD,  1,  0,  1, 7,  32'hABCD,2);
    tbl[3] = mk(0, 0, 0, 0,  0,       0, 0,  0,         0,  0,  0, 0,  0,       0);
    tbl[4] = mk(0, 1, 1, 0,  32'h22,  0, 0,  0,         0,  0,  0, 0,  32'h22,  1);
    tbl[5] = mk(0, 1, 1, 3,  32'h33,  1, 3,  32'h44,    1,  1,  1, 3,  32'h44,  2);
    tbl[6] = mk(0, 1, 1, 3,  32'h33,  0, 0,  0,         0,  0,  1, 3,  32'h33,  3);
    tbl[7] = mk(0, 1, 0, 6,  32'h66,  0, 0,  0,         0,  0,  0, 0,  0,       0);
    for (int i = 0; i < 8; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Starvation: MDU loses MAX_WAIT cycles, is forced on the next one.
    for (int i = 0; i < MAX_WAIT; i++)
      seq.push_back(mk(0, 1, 1, 5'(10+i), 32'h100+i, 1, 9, 32'h99,
                       0, 0, 1, 5'(10+i), 32'h100+i, 1));
    seq.push_back(mk(0, 1, 1, 5'(10+MAX_WAIT), 32'h100+MAX_WAIT, 1, 9, 32'h99,
                     1, 1, 1, 9, 32'h99, 2));
    seq.push_back(mk(0, 1, 1, 5'(10+MAX_WAIT), 32'h100+MAX_WAIT, 0, 0, 0,
                     0, 0, 1, 5'(10+MAX_WAIT), 32'h100+MAX_WAIT, 3));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Reset while holding: parked entry is dropped.
    seq.push_back(mk(0, 1, 1, 4, 32'h44, 1, 4, 32'h55, 1, 1, 1, 4, 32'h55, 2));
    seq.push_back(mk(1, 1, 1, 4, 32'h44, 0, 0, 0,      0, 0, 0, 0, 0, 0));
    seq.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0,      0, 0, 0, 0, 0, 0));
    foreach (seq[i]) apply($sformatf("seq%0d", i), seq[i]);

    // Randomized traffic against the model.
    m_parked = 0; m_losses = 0;
    mdu_pend = 0; pend_rd = 0; pend_data = 0;
    cur = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 400; c++) begin
      v = cur;
      v.rst = (c == 0) || ($urandom_range(0, 63) == 0);
      if (!mdu_pend && $urandom_range(0, 2) == 0) begin
        mdu_pend = 1; pend_rd = 5'($urandom_range(0, 3)); pend_data = $urandom;
      end
      v.mv = mdu_pend; v.mrd = mdu_pend ? pend_rd : 5'd0; v.mdata = mdu_pend ? pend_data : 0;
      if (!m_parked) begin
        v.pv = ($urandom_range(0, 3) != 0); v.pwe = ($urandom_range(0, 7) != 0);
        v.prd = 5'($urandom_range(0, 3)); v.pdata = $urandom;
      end
      v = model_step(v);
      if (v.e_ready || v.rst) mdu_pend = 0;
      apply($sformatf("rnd%0d", c), v);
      cur = v;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two sources:
  - the in-order pipeline writeback result (the output of the writeback mux);
  - a multi-cycle unit (MDU: mul/div) result.
- Sits between the writeback stage and the integer register file.
- A one-entry hold buffer lets the MDU win a cycle without a combinational stall back into the pipeline.
- A wait counter bounds MDU starvation.

Parameters:
- MAX_WAIT, 4, max consecutive cycles a valid MDU request may lose to the pipeline before it is forced through (>=1).

Ports:
- clk_in  input  1  clock, all state updates on rising edge
- rst_in  input  1  synchronous, active-high reset
- pipe_valid_in  input  1  pipeline writeback entry present
- pipe_rf_wr_en_in  input  1  entry writes the register file
- pipe_rd_in  input  5  destination register
- pipe_data_in  input  32  writeback mux result
- pipe_stall_out  output  1  pipeline must hold its writeback inputs (registered)
- mdu_valid_in  input  1  MDU result present; held stable until accepted
- mdu_rd_in  input  5  MDU destination register
- mdu_data_in  input  32  MDU result
- mdu_ready_out  output  1  MDU result accepted this cycle (combinational grant)
- rf_wr_en_out  output  1  register-file write enable (registered)
- rf_rd_addr_out  output  5  write address (registered)
- rf_wr_data_out  output  32  write data (registered)
- wb_src_out  output  2  source of the current write: 00 none, 01 pipe, 10 mdu, 11 held pipe

Behaviour:
- Reset: state PIPE; wait_cnt=0; hold empty. All outputs 0: pipe_stall_out, mdu_ready_out, rf_wr_en_out, rf_rd_addr_out, rf_wr_data_out, wb_src_out.
- Reset mid-operation: a held entry is discarded and the wait count is cleared.
- Latency: accepted entry appears on rf_* exactly 1 cycle later.
- Definitions:
  - pipe_wr = pipe_valid_in & pipe_rf_wr_en_in & (state==PIPE).
  - rd_match = mdu_rd_in == pipe_rd_in.
- State PIPE:
  - mdu_grant = mdu_valid_in & (!pipe_wr | wait_cnt==MAX_WAIT | rd_match).
  - mdu_grant & pipe_wr:
    - write MDU next cycle (wb_src 10);
    - capture pipe rd/data into hold;
    - go to HOLD.
  - mdu_grant & !pipe_wr: write MDU next cycle (wb_src 10). A pipe entry with pipe_rf_wr_en_in=0 is consumed with no write.
  - !mdu_grant & pipe_wr: write pipe next cycle (wb_src 01).
  - Nothing to write: rf_wr_en_out=0, wb_src 00.
- State HOLD:
  - pipe_stall_out=1; pipeline inputs ignored; mdu_ready_out=0.
  - Write held entry next cycle (wb_src 11); return to PIPE.
- wait_cnt:
  - cleared on mdu_grant or when mdu_valid_in=0;
  - otherwise increments while mdu_valid_in=1, saturating at MAX_WAIT.
- rd_match: forcing the MDU grant writes the older MDU result first, so the younger pipe value lands last.
- Writes to rd=0: the entry is consumed normally (handshakes, hold, wb_src) but rf_wr_en_out=0.
- Back-to-back: HOLD lasts exactly one cycle, so the pipeline is stalled at most 1 cycle per MDU conflict.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined:
  - adds output conflict_cnt_out[31:0], counting cycles where mdu_grant & pipe_wr (entries into HOLD);
  - adds output starve_cnt_out[31:0], counting forced grants where wait_cnt==MAX_WAIT;
  - both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (wb_arb_pkg):
  - wb_src encodings WB_SRC_NONE/PIPE/MDU/HOLD;
  - state encodings ST_PIPE/ST_HOLD;
  - REG_ADDR_W=5, XLEN=32.
- Natural sub-module: wb_hold_reg, the one-entry rd/data holding register with load/clear.
- Everything else is inline arbitration and the FSM.

Test Plan:
- Pipe-only stream: pipe_valid=1, wr_en=1, rd=5, data=0x11 -> next cycle rf_wr_en=1, addr=5, data=0x11, wb_src=01; no stall.
- MDU alone: mdu_valid=1, rd=7, data=0xABCD, pipe idle -> mdu_ready=1 same cycle; next cycle addr=7, data=0xABCD, wb_src=10.
- Starvation with MAX_WAIT=4 (pipe writing every cycle, MDU valid):
  - MDU loses 4 cycles, then is granted on the 5th cycle;
  - pipe entry held; pipe_stall_out=1 for one cycle;
  - writes in order: MDU (10), then held pipe (11).
- Same rd: MDU rd=3 and pipe rd=3 both valid -> immediate MDU grant; rf writes MDU value then pipe value to x3.
- rd=0 pipe entry -> consumed with wb_src=01 and rf_wr_en_out=0.
- rst_in asserted while in HOLD -> next cycle all outputs 0, state PIPE, held entry not written.
